// File: rtl/mp_cond_sub.sv
// Conditional subtraction after the 1028-bit adder: computes T - M one 64-bit limb per
// cycle and returns T mod M for T < 2M, flagging T >= 2M as a range error.
module mp_cond_sub (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [1027:0] in_t,
  input  logic [1023:0] in_m,
  output logic [1023:0] result,
  output logic          done,
  output logic          busy,
  output logic          range_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    SEL  = 2'd2
  } state_t;

  state_t         state;
  logic [1087:0]  t_q;
  logic [1087:0]  m_q;
  logic [1087:0]  d_q;
  logic [1023:0]  t_keep;
  logic           borrow;
  logic           cmp_borrow;
  logic [4:0]     count;

  logic [64:0]    diff_w;
  logic           cmp_bout;

  // The second chain compares each fresh difference limb against the same M limb, so
  // after 17 limbs cmp_borrow = 1 iff the whole 1088-bit difference is below M.
  always_comb begin
    diff_w   = {1'b0, t_q[63:0]} - {1'b0, m_q[63:0]} - {64'd0, borrow};
    cmp_bout = (diff_w[63:0] < m_q[63:0]) ||
               ((diff_w[63:0] == m_q[63:0]) && cmp_borrow);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      t_q        <= '0;
      m_q        <= '0;
      d_q        <= '0;
      t_keep     <= '0;
      borrow     <= 1'b0;
      cmp_borrow <= 1'b0;
      count      <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t_q        <= {60'd0, in_t};
            m_q        <= {64'd0, in_m};
            t_keep     <= in_t[1023:0];
            borrow     <= 1'b0;
            cmp_borrow <= 1'b0;
            count      <= '0;
            busy       <= 1'b1;
            state      <= SUB;
          end
        end
        SUB: begin
          d_q        <= {diff_w[63:0], d_q[1087:64]};
          t_q        <= {64'd0, t_q[1087:64]};
          m_q        <= {64'd0, m_q[1087:64]};
          borrow     <= diff_w[64];
          cmp_borrow <= cmp_bout;
          count      <= count + 5'd1;
          if (count == 5'd16) begin
            state <= SEL;
          end
        end
        SEL: begin
          result     <= borrow ? t_keep : d_q[1023:0];
          range_err  <= !borrow && !cmp_borrow;
          done       <= 1'b1;
          busy       <= 1'b0;
          borrow     <= 1'b0;
          cmp_borrow <= 1'b0;
          count      <= '0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_cond_sub.sv
// Randomized self-checking bench for mp_cond_sub against a plain-arithmetic T mod M model.
module tb_mp_cond_sub;

  typedef logic [1119:0] big_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1027:0] in_t = '0;
  logic [1023:0] in_m = '0;
  logic [1023:0] result;
  logic          done;
  logic          busy;
  logic          range_err;

  int checks = 0;
  int errors = 0;

  mp_cond_sub dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .in_t      (in_t),
    .in_m      (in_m),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Reference: T mod M for T < 2M, T - M (truncated) otherwise, error iff T >= 2M.
  function automatic void ref_model(input big_t t, input big_t m,
                                    output logic [1023:0] res, output logic err);
    big_t d;
    if (t < m) d = t;
    else d = t - m;
    res = d[1023:0];
    err = (t >= 2 * m);
  endfunction

  function automatic big_t rand_big();
    big_t v;
    v = '0;
    for (int i = 0; i < 35; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Issues one start pulse and waits (bounded) for done; lat = edges from start to done.
  task automatic do_op(input big_t t, input big_t m, output int lat);
    @(posedge clk); #1;
    in_t  = t[1027:0];
    in_m  = m[1023:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (result !== '0 || done !== 1'b0 || busy !== 1'b0 || range_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%0h done=%b busy=%b range_err=%b, required all zero",
               result, done, busy, range_err);
    end
    resetn = 1'b1;
    $display("reset: result=%0h done=%b busy=%b", result, done, busy);
  endtask

  task automatic test_known();
    big_t tv [4];
    big_t mv [4];
    logic [1023:0] exp_r;
    logic exp_e;
    int lat;
    big_t one;
    one = 1;
    tv[0] = 5;                                  mv[0] = 7;
    tv[1] = (one << 1024) + 3;                  mv[1] = (one << 1024) - 1;
    mv[2] = (one << 1023) + (one << 64) - 1;    tv[2] = mv[2];
    mv[3] = 64'hFFFF_FFFF_FFFF_FFFF;            tv[3] = 3 * mv[3];
    for (int k = 0; k < 4; k++) begin
      ref_model(tv[k], mv[k], exp_r, exp_e);
      do_op(tv[k], mv[k], lat);
      checks++;
      if (lat != 18) begin
        errors++;
        $display("FAIL known%0d latency: got %0d cycles, required 18", k, lat);
      end
      checks++;
      if (result !== exp_r || range_err !== exp_e) begin
        errors++;
        $display("FAIL known%0d result: got %0h err=%b, required %0h err=%b",
                 k, result, range_err, exp_r, exp_e);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL known%0d done_width: done=%b busy=%b one cycle later, required 0 0",
                 k, done, busy);
      end
      $display("known%0d: lat=%0d result=%0h range_err=%b", k, lat, result, range_err);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int lat;
    @(posedge clk); #1;
    in_t  = 9;
    in_m  = 4;
    start = 1'b1;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset busy_after_start: busy=%b, required 1", busy);
    end
    repeat (6) @(posedge clk);        // through E6
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;               // E7 samples reset
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0 || result !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset abort: dones=%0d result=%0h busy=%b, required 0 0 0",
               dones, result, busy);
    end
    do_op(9, 4, lat);
    checks++;
    if (lat != 18 || result !== 1024'd5) begin
      errors++;
      $display("FAIL mid_reset restart: lat=%0d result=%0h, required 18 5", lat, result);
    end
    $display("mid_reset: aborted dones=%0d restart result=%0h", dones, result);
  endtask

  task automatic test_start_busy();
    int dones;
    @(posedge clk); #1;
    in_t  = 50;
    in_m  = 30;
    start = 1'b1;
    @(posedge clk); #1;               // E0
    start = 1'b0;
    repeat (4) @(posedge clk);        // through E4
    #1;
    in_t  = 999;
    in_m  = 7;
    start = 1'b1;
    @(posedge clk); #1;               // E5
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (result !== 1024'd20 || range_err !== 1'b0) begin
          errors++;
          $display("FAIL start_busy result: got %0h err=%b, required 14 err=0",
                   result, range_err);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL start_busy done_count: got %0d, required 1", dones);
    end
    $display("start_busy: dones=%0d result=%0h", dones, result);
  endtask

  task automatic test_back_to_back();
    int gap;
    int lat;
    @(posedge clk); #1;
    in_t  = 50;
    in_m  = 30;
    start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (done !== 1'b1 && gap < 40);
    start = 1'b0;
    checks++;
    if (lat != 18 || gap != 19) begin
      errors++;
      $display("FAIL back_to_back spacing: lat=%0d gap=%0d, required 18 19", lat, gap);
    end
    checks++;
    if (result !== 1024'd20) begin
      errors++;
      $display("FAIL back_to_back result: got %0h, required 14", result);
    end
    repeat (25) @(posedge clk);
    #1;
    $display("back_to_back: lat=%0d gap=%0d result=%0h", lat, gap, result);
  endtask

  task automatic test_random();
    big_t m, t;
    logic [1023:0] exp_r;
    logic exp_e;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      m = rand_big();
      m[1119:1024] = '0;
      m = m >> $urandom_range(0, 1000);
      if (m == 0) m = 1;
      t = rand_big() % (2 * m);
      ref_model(t, m, exp_r, exp_e);
      do_op(t, m, lat);
      checks++;
      if (lat != 18 || result !== exp_r || range_err !== exp_e) begin
        errors++;
        $display("FAIL random%0d: lat=%0d result=%0h err=%b, required lat=18 result=%0h err=%b",
                 n, lat, result[127:0], range_err, exp_r[127:0], exp_e);
      end
      $display("random%0d: lat=%0d result_lo=%0h", n, lat, result[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_cond_sub.md
# mp_cond_sub

Final conditional-subtraction stage of the Montgomery datapath, placed directly downstream of the 1028-bit multi-precision adder. It takes the adder's 1028-bit result T and the 1024-bit modulus M, computes T − M one 64-bit limb per cycle with a registered borrow chain, and returns T mod M when T < 2M. It also flags an out-of-range input.

## Interface
- No parameters. Limb width is fixed at 64 bits, limb count at 17 (1088 bits), modulus width at 1024 bits.
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- in_t  input  1028  operand T (adder result); sampled on the start edge only.
- in_m  input  1024  modulus M; sampled on the start edge only.
- result  output  1024  reduced value, held until the next completion or reset.
- done  output  1  one-cycle pulse when result is valid.
- busy  output  1  high from the start edge until the done edge, inclusive of the SEL cycle.
- range_err  output  1  valid with done; set when T ≥ 2M (result not fully reduced).

## Operation
- States:
  - IDLE: waiting for start.
  - SUB: limb loop, 17 cycles, counter 0..16.
  - SEL: writes result, done, range_err.
- Transitions:
  - IDLE→SUB on start.
  - SUB→SEL when count = 16.
  - SEL→IDLE unconditionally.
  - Any undefined state→IDLE.
- Start edge: T is zero-extended to 1088 bits into shift register tQ. M is zero-extended to 1088 bits into mQ. A copy of T[1023:0] goes into tKeep. count←0, borrow←0.
- SUB, each cycle:
  - {b_out, d} = tQ[63:0] − mQ[63:0] − borrow, computed as a 64-bit subtract with borrow.
  - d shifts into the top of the difference register dQ (1088 bits, right-shift by 64).
  - tQ and mQ shift right by 64.
  - borrow←b_out; count←count+1.
- After 17 limbs, dQ holds T − M mod 2^1088 and borrow = 1 iff T < M.
- SEL:
  - If borrow = 1: result←tKeep.
  - Else: result←dQ[1023:0].
  - range_err←(borrow = 0) && (dQ[1087:1024] ≠ 0 || dQ[1023:0] ≥ M_saved). This requires a saved copy of M, M_saved (1024 bits), loaded on the start edge. The comparison is evaluated by the same limb loop: a second borrow chain runs on dQ limbs against M one cycle behind, or an equivalent registered compare. Either is acceptable provided the timing below is met.
  - done←1; borrow and count cleared.
- start while busy is ignored; it is neither queued nor allowed to alter any register.
- in_t/in_m may change freely after the start edge.

## Timing
- Reset (resetn = 0 at an edge):
  - state←IDLE.
  - result←0, done←0, busy←0, range_err←0.
  - tQ, mQ, dQ, borrow and count cleared.
  - Reset mid-operation aborts with no done pulse.
- Let E0 be the edge where start is sampled in IDLE.
  - Limb i is processed at edge E(i+1), i = 0..16.
  - SEL executes at E18.
  - done is high for exactly the cycle after E18.
  - result and range_err update at E18.
- Latency is 18 cycles from start edge to done edge.
  - busy is high after E0 and low after E18.
  - The next start is accepted at E19 at the earliest. start held high continuously gives back-to-back operations every 19 cycles.
- done is registered, never combinational. result is stable whenever done = 1 and stays stable until the next E18 or reset.
- Borrow into limb 0 is always 0. Bits of T above 1027 and bits of M above 1023 are treated as 0.

## Test plan
- T = 5, M = 7:
  - borrow = 1, so result = 5, range_err = 0.
  - done exactly 18 cycles after start, width 1.
- T = 2^1024 + 3, M = 2^1024 − 1:
  - Borrow propagates across all limbs, so result = 4, range_err = 0.
- T = M = 2^1023 + 2^64 − 1:
  - result = 0, range_err = 0. This is the equality boundary.
- T = 3M with M = 0xFFFF_FFFF_FFFF_FFFF:
  - result = 2M = 0x1_FFFF_FFFF_FFFF_FFFE, range_err = 1.
- Reset mid-operation:
  - Start T = 9, M = 4, then drop resetn for one cycle at E7.
  - No done pulse; result = 0, busy = 0.
  - A fresh start then yields result = 5.
- Start while busy plus random sweep:
  - A start pulsed at E5 is ignored; only one done occurs, and result matches the first operands.
  - 1000 random T < 2M checked against reference T mod M.
